micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have parameter DATA_BUS_IN, default 11, control-store address width.
REQ-002 SHALL have parameter DATA_BUS_OUT, default 41, microword width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles a memory microinstruction is held awaiting MEM_ACK (legal range 2..255).
REQ-004 SHALL use one clock and an asynchronous, active-low reset: CLOCK_50 input 1, the sole clock, rising edge.
REQ-005 RESET_InLow  input  1  asynchronous active-low reset.
REQ-006 ROM_ADDR  output  11  next control-store address, driven to the control-store ROM address bus.
REQ-007 ROM_DATA  input  41  microword returned combinationally by the ROM for ROM_ADDR.
REQ-008 IR  input  32  instruction register; uses [31:30] (op), [24:19] (op3) and [13] (i).
REQ-009 PSR_NZVC  input  4  condition codes: [3]=N, [2]=Z, [1]=V, [0]=C.
REQ-010 MEM_ACK  input  1  memory completion for the current RD/WR microinstruction.
REQ-011 MIR_A, MIR_B, MIR_C  output  6 each; MIR_AMUX, MIR_BMUX, MIR_CMUX, MIR_RD, MIR_WR  output  1 each; MIR_ALU  output  4. All are registered microword fields.
REQ-012 UPC  output  11  address of the microword currently held in MIR.
REQ-013 MEM_TIMEOUT  output  1  sticky flag, set when a memory microinstruction is forced past TIMEOUT.

Function
REQ-014 Microword fields SHALL be split as [40:35]A, [34]AMUX, [33:28]B, [27]BMUX, [26:21]C, [20]CMUX, [19]RD, [18]WR, [17:14]ALU, [13:11]COND, [10:0]JUMP.
REQ-015 The block SHALL hold a 41-bit MIR register, an 11-bit UPC register, an 8-bit wait counter and a state register with states BOOT, RUN and WAIT.
REQ-016 In BOOT, ROM_ADDR SHALL be 0; on the next edge MIR<=ROM_DATA, UPC<=0 and the state goes to RUN.
REQ-017 In RUN and WAIT, ROM_ADDR SHALL be computed combinationally from MIR.COND:
- 000: UPC+1.
- 001: N ? JUMP : UPC+1.
- 010: Z ? JUMP : UPC+1.
- 011: V ? JUMP : UPC+1.
- 100: C ? JUMP : UPC+1.
- 101: IR[13] ? JUMP : UPC+1.
- 110: JUMP.
- 111: {1'b1, IR[31:30], IR[24:19], 2'b00}.
REQ-018 UPC+1 SHALL wrap modulo 2048, so 2047 gives 0.
REQ-019 Define advance = !(MIR_RD|MIR_WR) | MEM_ACK | (wait counter == TIMEOUT-1).
REQ-020 On an edge with advance=1, the block SHALL:
- load MIR<=ROM_DATA and UPC<=ROM_ADDR;
- clear the wait counter;
- move the state to RUN.
REQ-021 On an edge with advance=0, the block SHALL:
- hold MIR and UPC;
- increment the wait counter;
- move the state to WAIT.
REQ-022 If the advance is caused only by the counter reaching TIMEOUT-1 (MEM_ACK=0), MEM_TIMEOUT SHALL be set to 1 and stay 1 until reset.
REQ-023 MEM_ACK while MIR_RD=MIR_WR=0 SHALL be ignored.
REQ-024 If MIR_RD and MIR_WR are both 1, the pair SHALL be treated as one memory operation with a single acknowledge.
REQ-025 PSR_NZVC and IR SHALL be sampled combinationally in the cycle the branch is resolved; no internal copy is kept.
REQ-026 Throughput SHALL be one microinstruction per cycle when no memory operation is pending.
REQ-027 A memory microinstruction SHALL occupy MIR for at most TIMEOUT cycles.
REQ-028 All MIR_* outputs SHALL come directly from registers, with no combinational path from any input.

Reset
REQ-029 Asserting RESET_InLow=0 SHALL immediately, regardless of clock or state:
- force state BOOT;
- clear MIR to 0 (all MIR_* outputs 0);
- set UPC=0, wait counter=0 and MEM_TIMEOUT=0;
- drive ROM_ADDR=0.
REQ-030 Reset asserted during WAIT SHALL abandon the pending memory operation without setting MEM_TIMEOUT.
REQ-031 After RESET_InLow rises, the first rising edge SHALL load the microword at address 0.

Verification
REQ-032 Reset release with ROM word 0 = 0x10204A50000 -> ROM_ADDR=0 before the edge; after the edge UPC=0, MIR_RD=0 and MIR_ALU matches bits [17:14] of that word.
REQ-033 MIR.COND=111 with IR[31:30]=10 and IR[24:19]=010000 -> ROM_ADDR=1600; with IR[24:19]=010110 -> ROM_ADDR=1624.
REQ-034 UPC=8, COND=010, JUMP=12 -> Z=1 gives ROM_ADDR=12; Z=0 gives ROM_ADDR=9; UPC=2047 with COND=000 gives ROM_ADDR=0.
REQ-035 MIR_RD=1 and MEM_ACK low for 3 cycles then high -> MIR and UPC hold for 3 edges, load on the 4th edge, MEM_TIMEOUT=0.
REQ-036 MIR_WR=1 with MEM_ACK never asserted, TIMEOUT=255 -> forced advance on the 255th edge, MEM_TIMEOUT=1 and held through subsequent microinstructions.
REQ-037 Reset pulsed while in WAIT -> all outputs return to 0 asynchronously; after release, fetch restarts at address 0 with MEM_TIMEOUT=0.

Source files
------------

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram sequencer with a registered microinstruction register (MIR),
// condition/dispatch branching and memory-wait handling with a bounded timeout.
`default_nettype none

module micro_sequencer #(
  parameter int DATA_BUS_IN  = 11,
  parameter int DATA_BUS_OUT = 41,
  parameter int TIMEOUT      = 255
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_InLow,
  output logic [DATA_BUS_IN-1:0]  ROM_ADDR,
  input  logic [DATA_BUS_OUT-1:0] ROM_DATA,
  input  logic [31:0]             IR,
  input  logic [3:0]              PSR_NZVC,
  input  logic                    MEM_ACK,
  output logic [5:0]              MIR_A,
  output logic [5:0]              MIR_B,
  output logic [5:0]              MIR_C,
  output logic                    MIR_AMUX,
  output logic                    MIR_BMUX,
  output logic                    MIR_CMUX,
  output logic                    MIR_RD,
  output logic                    MIR_WR,
  output logic [3:0]              MIR_ALU,
  output logic [DATA_BUS_IN-1:0]  UPC,
  output logic                    MEM_TIMEOUT
);

  typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_WAIT = 2'd2} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t                  state;
  logic [DATA_BUS_OUT-1:0] mir;
  logic [7:0]              wait_cnt;

  logic [2:0]             cond;
  logic [DATA_BUS_IN-1:0] jump;
  logic [DATA_BUS_IN-1:0] upc_inc;
  logic [DATA_BUS_IN-1:0] next_addr;
  logic                   mem_op;
  logic                   cnt_last;
  logic                   advance;
  logic                   unused_ir;

  assign MIR_A    = mir[40:35];
  assign MIR_AMUX = mir[34];
  assign MIR_B    = mir[33:28];
  assign MIR_BMUX = mir[27];
  assign MIR_C    = mir[26:21];
  assign MIR_CMUX = mir[20];
  assign MIR_RD   = mir[19];
  assign MIR_WR   = mir[18];
  assign MIR_ALU  = mir[17:14];
  assign cond     = mir[13:11];
  assign jump     = mir[10:0];

  assign unused_ir = ^{IR[29:25], IR[18:14], IR[12:0]};

  assign upc_inc  = UPC + 1'b1;
  assign mem_op   = MIR_RD | MIR_WR;
  assign cnt_last = (wait_cnt == TMO_LAST);
  assign advance  = !mem_op | MEM_ACK | cnt_last;

  always_comb begin
    next_addr = upc_inc;
    case (cond)
      3'b001:  next_addr = PSR_NZVC[3] ? jump : upc_inc;
      3'b010:  next_addr = PSR_NZVC[2] ? jump : upc_inc;
      3'b011:  next_addr = PSR_NZVC[1] ? jump : upc_inc;
      3'b100:  next_addr = PSR_NZVC[0] ? jump : upc_inc;
      3'b101:  next_addr = IR[13] ? jump : upc_inc;
      3'b110:  next_addr = jump;
      3'b111:  next_addr = {1'b1, IR[31:30], IR[24:19], 2'b00};
      default: next_addr = upc_inc;
    endcase
  end

  // BOOT (also the reset state) always fetches address 0.
  assign ROM_ADDR = (state == S_BOOT) ? '0 : next_addr;

  always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      state       <= S_BOOT;
      mir         <= '0;
      UPC         <= '0;
      wait_cnt    <= '0;
      MEM_TIMEOUT <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          mir      <= ROM_DATA;
          UPC      <= '0;
          wait_cnt <= '0;
          state    <= S_RUN;
        end
        default: begin
          if (advance) begin
            mir      <= ROM_DATA;
            UPC      <= ROM_ADDR;
            wait_cnt <= '0;
            state    <= S_RUN;
            if (mem_op && !MEM_ACK && cnt_last)
              MEM_TIMEOUT <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            state    <= S_WAIT;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer with a behavioural control-store ROM.
`default_nettype none

module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] rom_addr;
  logic [40:0] rom_data;
  logic [31:0] ir;
  logic [3:0]  nzvc;
  logic        mem_ack;
  logic [5:0]  mir_a, mir_b, mir_c;
  logic        mir_amux, mir_bmux, mir_cmux, mir_rd, mir_wr;
  logic [3:0]  mir_alu;
  logic [10:0] upc;
  logic        mem_timeout;

  logic [40:0] rom [0:2047];
  int n_checks = 0;
  int n_fail   = 0;

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  micro_sequencer dut (
    .CLOCK_50   (clk),
    .RESET_InLow(rst_n),
    .ROM_ADDR   (rom_addr),
    .ROM_DATA   (rom_data),
    .IR         (ir),
    .PSR_NZVC   (nzvc),
    .MEM_ACK    (mem_ack),
    .MIR_A      (mir_a),
    .MIR_B      (mir_b),
    .MIR_C      (mir_c),
    .MIR_AMUX   (mir_amux),
    .MIR_BMUX   (mir_bmux),
    .MIR_CMUX   (mir_cmux),
    .MIR_RD     (mir_rd),
    .MIR_WR     (mir_wr),
    .MIR_ALU    (mir_alu),
    .UPC        (upc),
    .MEM_TIMEOUT(mem_timeout)
  );

  function automatic logic [40:0] mw(input logic rd, input logic wr, input logic [3:0] alu,
                                     input logic [2:0] cond, input logic [10:0] jump);
    mw = {6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, rd, wr, alu, cond, jump};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = '0;
    rom[0]    = 41'h10204A50000;            // WR=1, ALU=4, A=32, B=32, C=37, COND=000
    rom[1]    = mw(1'b0, 1'b0, 4'd1, 3'b111, 11'd0);
    rom[1624] = mw(1'b0, 1'b0, 4'd2, 3'b110, 11'd8);
    rom[8]    = mw(1'b0, 1'b0, 4'd3, 3'b010, 11'd12);
    rom[12]   = mw(1'b1, 1'b0, 4'd5, 3'b110, 11'd20);
    rom[20]   = mw(1'b0, 1'b0, 4'd6, 3'b110, 11'd8);
    rom[9]    = mw(1'b0, 1'b0, 4'd7, 3'b001, 11'd2047);
    rom[2047] = mw(1'b0, 1'b0, 4'd9, 3'b000, 11'd0);

    rst_n   = 1'b0;
    ir      = '0;
    nzvc    = 4'b0000;
    mem_ack = 1'b0;
    step(); step();

    // Reset state
    chk("rst_upc", 64'(upc), 64'd0);
    chk("rst_mir", 64'({mir_a, mir_b, mir_c, mir_amux, mir_bmux, mir_cmux, mir_rd, mir_wr, mir_alu}), 64'd0);
    chk("rst_tmo", 64'(mem_timeout), 64'd0);
    chk("rst_addr", 64'(rom_addr), 64'd0);

    rst_n = 1'b1;
    #1;
    chk("boot_addr", 64'(rom_addr), 64'd0);
    step();
    chk("boot_upc", 64'(upc), 64'd0);
    chk("boot_rd", 64'(mir_rd), 64'd0);
    chk("boot_wr", 64'(mir_wr), 64'd1);
    chk("boot_alu", 64'(mir_alu), 64'd4);
    chk("boot_a", 64'(mir_a), 64'd32);
    chk("boot_c", 64'(mir_c), 64'd37);
    chk("seq_addr", 64'(rom_addr), 64'd1);

    // Word 0 is a write; acknowledge it immediately
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("ack_upc", 64'(upc), 64'd1);

    // Dispatch: IR[31:30]=10, op3 selects the target
    ir[31:30] = 2'b10;
    ir[24:19] = 6'b010000;
    #1;
    chk("disp_1600", 64'(rom_addr), 64'd1600);
    ir[24:19] = 6'b010110;
    #1;
    chk("disp_1624", 64'(rom_addr), 64'd1624);
    step();
    chk("disp_upc", 64'(upc), 64'd1624);
    chk("disp_alu", 64'(mir_alu), 64'd2);
    step();
    chk("jmp_upc", 64'(upc), 64'd8);

    // Z branch at UPC=8, JUMP=12
    nzvc = 4'b0100;
    #1;
    chk("z1_addr", 64'(rom_addr), 64'd12);
    nzvc = 4'b0000;
    #1;
    chk("z0_addr", 64'(rom_addr), 64'd9);
    nzvc = 4'b0100;
    step();
    nzvc = 4'b0000;
    chk("rd_upc", 64'(upc), 64'd12);
    chk("rd_flag", 64'(mir_rd), 64'd1);

    // Read held for three edges, then acknowledged
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rd_hold_upc", 64'(upc), 64'd12);
      chk("rd_hold_alu", 64'(mir_alu), 64'd5);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("rd_done_upc", 64'(upc), 64'd20);
    chk("rd_done_tmo", 64'(mem_timeout), 64'd0);

    step();
    chk("back8_upc", 64'(upc), 64'd8);
    step();
    chk("n_start_upc", 64'(upc), 64'd9);
    nzvc = 4'b1000;
    #1;
    chk("n1_addr", 64'(rom_addr), 64'd2047);
    step();
    nzvc = 4'b0000;
    chk("top_upc", 64'(upc), 64'd2047);
    chk("wrap_addr", 64'(rom_addr), 64'd0);
    step();
    chk("wrap_upc", 64'(upc), 64'd0);
    chk("wrap_wr", 64'(mir_wr), 64'd1);

    // Write never acknowledged: 254 holding edges, forced advance on the 255th
    for (int k = 0; k < 254; k++) step();
    chk("tmo_hold_upc", 64'(upc), 64'd0);
    chk("tmo_hold_flag", 64'(mem_timeout), 64'd0);
    step();
    chk("tmo_adv_upc", 64'(upc), 64'd1);
    chk("tmo_set", 64'(mem_timeout), 64'd1);
    step();
    step();
    chk("tmo_sticky_upc", 64'(upc), 64'd8);
    chk("tmo_sticky", 64'(mem_timeout), 64'd1);

    // Enter WAIT on the read at 12, then pulse reset mid-cycle
    nzvc = 4'b0100;
    step();
    nzvc = 4'b0000;
    step();
    chk("wait_upc", 64'(upc), 64'd12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_upc", 64'(upc), 64'd0);
    chk("arst_mir", 64'({mir_a, mir_b, mir_c, mir_amux, mir_bmux, mir_cmux, mir_rd, mir_wr, mir_alu}), 64'd0);
    chk("arst_tmo", 64'(mem_timeout), 64'd0);
    chk("arst_addr", 64'(rom_addr), 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    step();
    chk("refetch_upc", 64'(upc), 64'd0);
    chk("refetch_alu", 64'(mir_alu), 64'd4);
    chk("refetch_tmo", 64'(mem_timeout), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
